cu_alu_ctrl: RTL and testbench

- Control/execute unit of the 8-bit CPU datapath.
- Accepts one 19-bit instruction per cycle, made of a 3-bit opcode and two 8-bit immediate operands.
- Decodes the opcode, performs the selected 8-bit operation and registers the 8-bit result.
- Sits between the instruction fetch stage and the writeback/display logic.

---
 rtl/cu_alu_ctrl.sv | 112 +++++++++++
 tb/tb_cu_alu_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cu_alu_ctrl.sv
// Control/execute unit for the 8-bit CPU datapath: decodes one instruction per cycle and registers the ALU result.
// Optional status flags (zero/carry/negative) are built only when CU_FLAGS_EN is defined.
module cu_alu_ctrl #(
  parameter int DATA_W = 8,
  parameter int OPC_W  = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_instr_valid,
  input  logic [OPC_W+2*DATA_W-1:0]     i_instruction,
  output logic [DATA_W-1:0]             o_result,
  output logic                          o_result_valid
`ifdef CU_FLAGS_EN
  ,
  output logic                          o_zero,
  output logic                          o_carry,
  output logic                          o_negative
`endif
);

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_NOT = 3'b110,
    OP_SHL = 3'b111
  } opc_e;

  opc_e              w_opc;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_res;
  logic              w_exec;

  logic [DATA_W-1:0] r_result;
  logic              r_result_valid;

  assign w_opc  = opc_e'(i_instruction[OPC_W+2*DATA_W-1:2*DATA_W]);
  assign w_a    = i_instruction[2*DATA_W-1:DATA_W];
  assign w_b    = i_instruction[DATA_W-1:0];
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;
  // NOP is accepted (result_valid pulses) but leaves result and flags untouched
  assign w_exec = i_instr_valid && (w_opc != OP_NOP);

  always_comb begin
    w_res = '0;
    case (w_opc)
      OP_ADD:  w_res = w_sum;
      OP_SUB:  w_res = w_diff;
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_NOT:  w_res = ~w_a;
      OP_SHL:  w_res = {w_a[DATA_W-2:0], 1'b0};
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= i_instr_valid;
      if (w_exec) r_result <= w_res;
    end
  end

  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;

`ifdef CU_FLAGS_EN
  logic w_cry;
  logic r_zero;
  logic r_carry;
  logic r_negative;

  // Carry out of ADD shows as a wrapped sum smaller than an operand; SUB borrow is A<B
  always_comb begin
    w_cry = 1'b0;
    case (w_opc)
      OP_ADD:  w_cry = (w_sum < w_a);
      OP_SUB:  w_cry = (w_a < w_b);
      OP_SHL:  w_cry = w_a[DATA_W-1];
      default: w_cry = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_zero     <= 1'b1;
      r_carry    <= 1'b0;
      r_negative <= 1'b0;
    end else if (w_exec) begin
      r_zero     <= (w_res == '0);
      r_carry    <= w_cry;
      r_negative <= w_res[DATA_W-1];
    end
  end

  assign o_zero     = r_zero;
  assign o_carry    = r_carry;
  assign o_negative = r_negative;
`endif

endmodule

// File: tb/tb_cu_alu_ctrl.sv
// Directed-vector bench for cu_alu_ctrl; flag checks are compiled in when CU_FLAGS_EN is defined.
module tb_cu_alu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [18:0] instruction;
  logic [7:0]  result;
  logic        result_valid;
`ifdef CU_FLAGS_EN
  logic        zero;
  logic        carry;
  logic        negative;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  cu_alu_ctrl #(.DATA_W(8), .OPC_W(3)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_instr_valid  (instr_valid),
    .i_instruction  (instruction),
    .o_result       (result),
    .o_result_valid (result_valid)
`ifdef CU_FLAGS_EN
    ,
    .o_zero         (zero),
    .o_carry        (carry),
    .o_negative     (negative)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  // Present an instruction at the falling edge, then sample 1ns after the next rising edge
  task automatic issue(input logic v, input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    instr_valid = v;
    instruction = {opc, a, b};
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic z, input logic c, input logic n);
`ifdef CU_FLAGS_EN
    check({tag, ".zero"},     {7'd0, zero},     {7'd0, z});
    check({tag, ".carry"},    {7'd0, carry},    {7'd0, c});
    check({tag, ".negative"}, {7'd0, negative}, {7'd0, n});
`else
    if (z === 1'bx && c === 1'bx && n === 1'bx) $display("note %s", tag);
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instruction = '0;
    #12;
    check("rst.result", result, 8'h00);
    check("rst.valid", {7'd0, result_valid}, 8'h00);
    chk_flags("rst", 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 3'b000, 8'h00, 8'h00);
    issue(1'b0, 3'b001, 8'h55, 8'h66);
    check("idle.result", result, 8'h00);
    check("idle.valid", {7'd0, result_valid}, 8'h00);
    chk_flags("idle", 1'b1, 1'b0, 1'b0);

    // Back-to-back ops with A=23, B=14
    issue(1'b1, 3'b001, 8'h23, 8'h14);
    check("add.result", result, 8'h37);
    check("add.valid", {7'd0, result_valid}, 8'h01);
    chk_flags("add", 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'b010, 8'h23, 8'h14);
    check("sub.result", result, 8'h0F);
    chk_flags("sub", 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'b011, 8'h23, 8'h14);
    check("and.result", result, 8'h00);
    chk_flags("and", 1'b1, 1'b0, 1'b0);
    issue(1'b1, 3'b100, 8'h23, 8'h14);
    check("or.result", result, 8'h37);
    issue(1'b1, 3'b101, 8'h23, 8'h14);
    check("xor.result", result, 8'h37);
    issue(1'b1, 3'b110, 8'h23, 8'h14);
    check("not.result", result, 8'hDC);
    chk_flags("not", 1'b0, 1'b0, 1'b1);
    issue(1'b1, 3'b111, 8'h23, 8'h14);
    check("shl.result", result, 8'h46);
    check("shl.valid", {7'd0, result_valid}, 8'h01);
    chk_flags("shl", 1'b0, 1'b0, 1'b0);
    issue(1'b1, 3'b111, 8'hC1, 8'h00);
    check("shl_msb.result", result, 8'h82);
    chk_flags("shl_msb", 1'b0, 1'b1, 1'b1);

    // Wrap-around
    issue(1'b1, 3'b001, 8'hFF, 8'h01);
    check("add_wrap.result", result, 8'h00);
    chk_flags("add_wrap", 1'b1, 1'b1, 1'b0);
    issue(1'b1, 3'b010, 8'h00, 8'h01);
    check("sub_wrap.result", result, 8'hFF);
    chk_flags("sub_wrap", 1'b0, 1'b1, 1'b1);

    // NOP holds result and flags but still signals valid; idle drops valid
    issue(1'b1, 3'b001, 8'h23, 8'h14);
    check("hold_add.result", result, 8'h37);
    issue(1'b1, 3'b000, 8'hFF, 8'hFF);
    check("nop.result", result, 8'h37);
    check("nop.valid", {7'd0, result_valid}, 8'h01);
    chk_flags("nop", 1'b0, 1'b0, 1'b0);
    issue(1'b0, 3'b001, 8'hFF, 8'hFF);
    check("hold_idle.result", result, 8'h37);
    check("hold_idle.valid", {7'd0, result_valid}, 8'h00);

    // Async reset mid-stream
    issue(1'b1, 3'b001, 8'h80, 8'h01);
    check("stream.result", result, 8'h81);
    chk_flags("stream", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    instruction = {3'b001, 8'h10, 8'h20};
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.result", result, 8'h00);
    check("async_rst.valid", {7'd0, result_valid}, 8'h00);
    chk_flags("async_rst", 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_held.result", result, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 3'b001, 8'h05, 8'h06);
    check("post_rst.result", result, 8'h0B);
    check("post_rst.valid", {7'd0, result_valid}, 8'h01);
    chk_flags("post_rst", 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
